// File: rtl/rv_wb_pkg.sv
// ============================================================================
//  Module      : rv_wb_pkg
//  Description : Shared widths and source encoding for the writeback scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv_wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-request round-robin arbiter; pointer moves on contention.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
    import rv_wb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    src_e r_ptr;

    // Grants are suppressed while reset is asserted so held requests re-arbitrate.
    always_comb begin
        gnt = 2'b00;
        if (reset) begin
            if (req == 2'b11) begin
                gnt = (r_ptr == SRC_ALU) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= SRC_ALU;
        end else if (req == 2'b11) begin
            r_ptr <= (r_ptr == SRC_ALU) ? SRC_LSU : SRC_ALU;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_sched.sv
// ============================================================================
//  Module      : regfile_wb_sched
//  Description : Register-file writeback scheduler with pending-write scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wb_sched #(
    parameter int XLEN       = rv_wb_pkg::XLEN,
    parameter int REG_ADDR_W = rv_wb_pkg::REG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      iss_valid,
    input  logic [REG_ADDR_W-1:0]     iss_rs1,
    input  logic [REG_ADDR_W-1:0]     iss_rs2,
    input  logic [REG_ADDR_W-1:0]     iss_rd,
    input  logic                      iss_wr,
    output logic                      iss_stall,
    input  logic                      s0_valid,
    input  logic [REG_ADDR_W-1:0]     s0_rd,
    input  logic [XLEN-1:0]           s0_data,
    output logic                      s0_ready,
    input  logic                      s1_valid,
    input  logic [REG_ADDR_W-1:0]     s1_rd,
    input  logic [XLEN-1:0]           s1_data,
    output logic                      s1_ready,
    output logic                      rf_we,
    output logic [REG_ADDR_W-1:0]     rf_rd,
    output logic [XLEN-1:0]           rf_wdata,
    output logic [2**REG_ADDR_W-1:0]  busy_vec,
    output logic                      err_unexp
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_busy_nxt;
    logic                  r_we;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]       r_wdata;
    logic                  r_err;

    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic                  w_acc;
    logic                  w_acc_wr;
    logic [REG_ADDR_W-1:0] w_acc_rd;
    logic [XLEN-1:0]       w_acc_data;
    logic                  w_busy_rs1;
    logic                  w_busy_rs2;
    logic                  w_busy_rd;
    logic                  w_fire;

    assign w_req = {s1_valid, s0_valid};

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (w_req),
        .gnt   (w_gnt)
    );

    assign s0_ready   = w_gnt[0];
    assign s1_ready   = w_gnt[1];
    assign w_acc      = |(w_req & w_gnt);
    assign w_acc_rd   = w_gnt[1] ? s1_rd   : s0_rd;
    assign w_acc_data = w_gnt[1] ? s1_data : s0_data;
    // An accepted x0 result is consumed without touching the register file.
    assign w_acc_wr   = w_acc & (w_acc_rd != '0);

    assign w_busy_rs1 = (iss_rs1 != '0) & r_busy[iss_rs1];
    assign w_busy_rs2 = (iss_rs2 != '0) & r_busy[iss_rs2];
    assign w_busy_rd  = (iss_rd  != '0) & r_busy[iss_rd];
    assign iss_stall  = iss_valid & (w_busy_rs1 | w_busy_rs2 | (iss_wr & w_busy_rd));
    assign w_fire     = iss_valid & ~iss_stall;

    // Clear is applied before set so a forced same-index collision leaves the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we) begin
            w_busy_nxt[r_rd] = 1'b0;
        end
        if (w_fire && iss_wr && (iss_rd != '0)) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy  <= '0;
            r_we    <= 1'b0;
            r_rd    <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_we   <= w_acc_wr;
            if (w_acc_wr) begin
                r_rd    <= w_acc_rd;
                r_wdata <= w_acc_data;
            end
            if (r_we && !r_busy[r_rd]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rf_we     = r_we;
    assign rf_rd     = r_rd;
    assign rf_wdata  = r_wdata;
    assign busy_vec  = r_busy;
    assign err_unexp = r_err;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
// ============================================================================
//  Module      : tb_regfile_wb_sched
//  Description : Scoreboard bench for the writeback scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_sched;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NR   = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            iss_valid, iss_wr;
    logic [AW-1:0]   iss_rs1, iss_rs2, iss_rd;
    logic            iss_stall;
    logic            s0_valid, s1_valid;
    logic [AW-1:0]   s0_rd, s1_rd;
    logic [XLEN-1:0] s0_data, s1_data;
    logic            s0_ready, s1_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [NR-1:0]   busy_vec;
    logic            err_unexp;

    regfile_wb_sched dut (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_wr    (iss_wr),
        .iss_stall (iss_stall),
        .s0_valid  (s0_valid),
        .s0_rd     (s0_rd),
        .s0_data   (s0_data),
        .s0_ready  (s0_ready),
        .s1_valid  (s1_valid),
        .s1_rd     (s1_rd),
        .s1_data   (s1_data),
        .s1_ready  (s1_ready),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .busy_vec  (busy_vec),
        .err_unexp (err_unexp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Source queues hold {rd, data}; expected register-file writes in exp_q.
    logic [AW+XLEN-1:0] s0_q[$];
    logic [AW+XLEN-1:0] s1_q[$];
    logic [AW+XLEN-1:0] exp_q[$];

    // Reference model state
    logic [NR-1:0] m_busy;
    logic          m_ptr;
    logic [AW-1:0] m_wr;
    logic          m_err;
    logic          last_stall;
    int            n_writes = 0;

    function automatic logic mb(input logic [AW-1:0] r);
        return (r != '0) && m_busy[r];
    endfunction

    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check_eq("rf_we_unexp", 64'(rf_we), 64'd0);
            end else begin
                logic [AW+XLEN-1:0] e;
                e = exp_q.pop_front();
                check_eq("rf_rd",    64'(rf_rd),    64'(e[AW+XLEN-1:XLEN]));
                check_eq("rf_wdata", 64'(rf_wdata), 64'(e[XLEN-1:0]));
            end
        end
    end

    task automatic cycle();
        logic v0, v1, g0, g1, acc, stall;
        logic [AW-1:0]   ard;
        logic [XLEN-1:0] adata;
        v0 = (s0_q.size() > 0);
        v1 = (s1_q.size() > 0);
        s0_valid = v0;
        s1_valid = v1;
        {s0_rd, s0_data} = v0 ? s0_q[0] : '0;
        {s1_rd, s1_data} = v1 ? s1_q[0] : '0;
        #1;
        stall = iss_valid & (mb(iss_rs1) | mb(iss_rs2) | (iss_wr & mb(iss_rd)));
        g0 = 1'b0;
        g1 = 1'b0;
        if (reset) begin
            if (v0 && v1) begin
                g0 = ~m_ptr;
                g1 = m_ptr;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        check_eq("iss_stall", 64'(iss_stall), 64'(stall));
        check_eq("s0_ready",  64'(s0_ready),  64'(g0));
        check_eq("s1_ready",  64'(s1_ready),  64'(g1));
        check_eq("busy_vec",  64'(busy_vec),  64'(m_busy));
        check_eq("err_unexp", 64'(err_unexp), 64'(m_err));
        acc   = g0 | g1;
        ard   = g1 ? s1_rd   : s0_rd;
        adata = g1 ? s1_data : s0_data;
        if (g0) void'(s0_q.pop_front());
        if (g1) void'(s1_q.pop_front());
        if (acc && ard != '0) exp_q.push_back({ard, adata});
        @(posedge clk);
        if (!reset) begin
            m_busy = '0;
            m_ptr  = 1'b0;
            m_wr   = '0;
            m_err  = 1'b0;
        end else begin
            if (m_wr != '0) begin
                if (!m_busy[m_wr]) m_err = 1'b1;
                m_busy[m_wr] = 1'b0;
            end
            if (iss_valid && !stall && iss_wr && iss_rd != '0) m_busy[iss_rd] = 1'b1;
            if (v0 && v1) m_ptr = ~m_ptr;
            m_wr = acc ? ard : '0;
        end
        last_stall = stall;
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = rd; iss_rs1 = '0; iss_rs2 = '0;
        cycle();
        iss_valid = 1'b0; iss_wr = 1'b0; iss_rd = '0;
    endtask

    initial begin
        int n;
        m_busy = '0; m_ptr = 1'b0; m_wr = '0; m_err = 1'b0; last_stall = 1'b0;
        iss_valid = 1'b0; iss_wr = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
        s1_valid = 1'b0; s1_rd = '0; s1_data = '0;
        // Reset held with an x0 ALU result pending; it must wait for release.
        reset = 1'b0;
        s0_q.push_back({5'd0, 32'h0000_0BAD});
        s0_valid = 1'b1; s0_rd = '0; s0_data = 32'h0000_0BAD;
        @(posedge clk); #1;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();

        // Single write
        issue(5'd5);
        s0_q.push_back({5'd5, 32'hDEAD_BEEF});
        repeat (3) cycle();

        // RAW stall lasts through the rf_we cycle
        issue(5'd7);
        iss_valid = 1'b1; iss_rs1 = 5'd7; iss_rs2 = '0; iss_wr = 1'b0;
        s1_q.push_back({5'd7, 32'hCAFE_0007});
        n = 0;
        do begin
            cycle();
            if (last_stall) n++;
        end while (last_stall && n < 10);
        check_eq("raw_stall_cycles", 64'(n), 64'd2);
        iss_rs1 = '0; iss_rs2 = '0;
        cycle();
        iss_valid = 1'b0;

        // Contention, with a WAW stall probe while x2 is pending
        for (int r = 1; r <= 4; r++) issue(AW'(r));
        iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd2;
        cycle();
        check_eq("waw_stall", 64'(last_stall), 64'd1);
        iss_valid = 1'b0; iss_wr = 1'b0; iss_rd = '0;
        n = n_writes;
        s0_q.push_back({5'd1, 32'h1111_0001});
        s1_q.push_back({5'd2, 32'h2222_0002});
        s0_q.push_back({5'd3, 32'h3333_0003});
        s1_q.push_back({5'd4, 32'h4444_0004});
        repeat (6) cycle();
        check_eq("contention_writes", 64'(n_writes - n), 64'd4);

        // x0 consumed; unexpected write sets sticky error
        n = n_writes;
        s0_q.push_back({5'd0, 32'h0000_0000});
        repeat (3) cycle();
        check_eq("x0_no_write", 64'(n_writes - n), 64'd0);
        s0_q.push_back({5'd9, 32'h1234_5678});
        repeat (5) cycle();
        check_eq("err_sticky", 64'(err_unexp), 64'd1);

        // Reset mid-operation with the load unit holding a result
        issue(5'd3);
        reset = 1'b0;
        s1_q.push_back({5'd3, 32'h5A5A_0003});
        cycle();
        reset = 1'b1;
        repeat (4) cycle();

        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        check_eq("src_drained", 64'(s0_q.size() + s1_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
